// File: rtl/sm2_decoder_agc.sv
// Decodes 2-bit sign/magnitude samples to signed levels (1-cycle latency) and reports per-window
// magnitude occupancy with hi/lo flags for threshold AGC. No backpressure: every valid sample is taken.
module sm2_decoder_agc #(
  parameter int MAG_LEVEL = 3,
  parameter int OW        = 3,
  parameter int WIN_LOG2  = 10,
  parameter int HI_THR    = 400,
  parameter int LO_THR    = 280
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 sig_I,
  input  logic                 mag_I,
  input  logic                 in_valid,
  output logic signed [OW-1:0] out,
  output logic                 out_valid,
  output logic [WIN_LOG2:0]    mag_cnt,
  output logic                 mag_cnt_valid,
  output logic                 hi_flag,
  output logic                 lo_flag
);

  localparam logic signed [OW-1:0] POS_MAG = OW'(MAG_LEVEL);
  localparam logic signed [OW-1:0] NEG_MAG = OW'(-MAG_LEVEL);
  localparam logic signed [OW-1:0] POS_ONE = OW'(1);
  localparam logic signed [OW-1:0] NEG_ONE = OW'(-1);
  localparam logic [WIN_LOG2:0]    HI_T    = (WIN_LOG2+1)'(HI_THR);
  localparam logic [WIN_LOG2:0]    LO_T    = (WIN_LOG2+1)'(LO_THR);

  logic signed [OW-1:0] dec;
  logic [WIN_LOG2-1:0]  smp_cnt;
  logic [WIN_LOG2:0]    acc;
  logic [WIN_LOG2:0]    acc_next;
  logic                 win_close;

  always_comb begin
    dec = POS_ONE;
    case ({sig_I, mag_I})
      2'b00:   dec = POS_ONE;
      2'b01:   dec = POS_MAG;
      2'b10:   dec = NEG_ONE;
      default: dec = NEG_MAG;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= dec;
    end
  end

  // The closing sample is folded into the reported count, never into the next window.
  assign acc_next  = acc + (WIN_LOG2+1)'(mag_I);
  assign win_close = in_valid && (smp_cnt == '1);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      smp_cnt       <= '0;
      acc           <= '0;
      mag_cnt       <= '0;
      mag_cnt_valid <= 1'b0;
      hi_flag       <= 1'b0;
      lo_flag       <= 1'b0;
    end else begin
      mag_cnt_valid <= win_close;
      if (in_valid) begin
        smp_cnt <= smp_cnt + WIN_LOG2'(1);
        if (win_close) begin
          acc     <= '0;
          mag_cnt <= acc_next;
          hi_flag <= (acc_next > HI_T);
          lo_flag <= (acc_next < LO_T);
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm2_decoder_agc.sv
// Directed bench for sm2_decoder_agc: reset, level mapping, window counts, flags and strobe spacing.
module tb_sm2_decoder_agc;

  logic              clk;
  logic              RESET;
  logic              sig_I;
  logic              mag_I;
  logic              in_valid;
  logic signed [2:0] out;
  logic              out_valid;
  logic [10:0]       mag_cnt;
  logic              mag_cnt_valid;
  logic              hi_flag;
  logic              lo_flag;

  int checks = 0;
  int errors = 0;
  int vcount;
  int cnt_q[$];
  int pos_q[$];
  int exp_strobes = 0;
  int wpos = 0;
  int base;

  sm2_decoder_agc dut (
    .clk(clk), .RESET(RESET), .sig_I(sig_I), .mag_I(mag_I), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .mag_cnt(mag_cnt), .mag_cnt_valid(mag_cnt_valid),
    .hi_flag(hi_flag), .lo_flag(lo_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Valid samples accepted since reset, and a log of every strobe.
  always @(posedge clk or posedge RESET) begin
    if (RESET) vcount <= 0;
    else if (in_valid) vcount <= vcount + 1;
  end

  always @(negedge clk) begin
    if (mag_cnt_valid === 1'b1) begin
      cnt_q.push_back(int'(mag_cnt));
      pos_q.push_back(vcount);
    end
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic send(input bit v, input bit s, input bit m);
    @(negedge clk);
    in_valid = v;
    sig_I    = s;
    mag_I    = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    RESET    = 1'b1;
    @(negedge clk);
    RESET    = 1'b0;
  endtask

  task automatic run_window(input int ones, input bit tail, input bit gaps);
    bit m;
    for (int i = 0; i < 1024; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) send(1'b0, 1'b0, 1'b0);
      m = tail ? (i >= 1024 - ones) : (i < ones);
      send(1'b1, 1'($urandom_range(0, 1)), m);
    end
  endtask

  task automatic check_window(input string tag, input int exp_cnt, input bit exp_hi,
                              input bit exp_lo, input int exp_pos);
    exp_strobes++;
    send(1'b0, 1'b0, 1'b0);
    #1;
    check({tag, "_strobe"}, mag_cnt_valid, 1);
    check({tag, "_cnt"}, mag_cnt, exp_cnt);
    check({tag, "_hi"}, hi_flag, exp_hi);
    check({tag, "_lo"}, lo_flag, exp_lo);
    check({tag, "_nstrobes"}, cnt_q.size(), exp_strobes);
    if (pos_q.size() > 0) check({tag, "_pos"}, pos_q[$], exp_pos);
    else check({tag, "_pos"}, -1, exp_pos);
    send(1'b0, 1'b0, 1'b0);
    #1;
    check({tag, "_strobe_drop"}, mag_cnt_valid, 0);
    check({tag, "_cnt_hold"}, mag_cnt, exp_cnt);
  endtask

  initial begin
    RESET = 1'b1; in_valid = 1'b0; sig_I = 1'b0; mag_I = 1'b0;
    #12;
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mag_cnt", mag_cnt, 0);
    check("rst_mcv", mag_cnt_valid, 0);
    check("rst_hi", hi_flag, 0);
    check("rst_lo", lo_flag, 0);
    @(negedge clk);
    RESET = 1'b0;

    // Mapping sweep with 1-cycle latency, then an idle gap.
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    check("map_00", out, 1);
    check("map_00_vld", out_valid, 1);
    send(1'b1, 1'b1, 1'b0);
    check("map_01", out, 3);
    send(1'b1, 1'b1, 1'b1);
    check("map_10", out, -1);
    send(1'b0, 1'b0, 1'b0);
    check("map_11", out, -3);
    check("map_11_vld", out_valid, 1);
    send(1'b0, 1'b0, 1'b0);
    check("idle_vld", out_valid, 0);
    check("idle_hold", out, -3);

    // Asynchronous reset while streaming: outputs clear before any clock edge.
    send(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    RESET = 1'b1;
    #1;
    check("arst_out", out, 0);
    check("arst_out_valid", out_valid, 0);
    @(negedge clk);
    RESET = 1'b0;
    in_valid = 1'b0;
    send(1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b0, 1'b0);
    check("post_rst_out", out, 3);
    check("post_rst_vld", out_valid, 1);

    do_reset();
    run_window(341, 1'b0, 1'b1); wpos += 1024;
    check_window("w341", 341, 1'b0, 1'b0, wpos);
    run_window(1024, 1'b0, 1'b1); wpos += 1024;
    check_window("w1024", 1024, 1'b1, 1'b0, wpos);
    run_window(0, 1'b0, 1'b0); wpos += 1024;
    check_window("w0", 0, 1'b0, 1'b1, wpos);
    run_window(400, 1'b0, 1'b1); wpos += 1024;
    check_window("w400", 400, 1'b0, 1'b0, wpos);
    run_window(280, 1'b1, 1'b0); wpos += 1024;
    check_window("w280", 280, 1'b0, 1'b0, wpos);
    run_window(401, 1'b0, 1'b0); wpos += 1024;
    check_window("w401", 401, 1'b1, 1'b0, wpos);
    run_window(279, 1'b1, 1'b1); wpos += 1024;
    check_window("w279", 279, 1'b0, 1'b1, wpos);

    // Back-to-back: window N closes on mag=1, window N+1 starts the very next cycle.
    run_window(500, 1'b1, 1'b0);
    run_window(0, 1'b0, 1'b0);
    exp_strobes++;
    wpos += 2048;
    check_window("b2b", 0, 1'b0, 1'b1, wpos);
    if (cnt_q.size() >= 2) begin
      check("b2b_first_cnt", cnt_q[cnt_q.size()-2], 500);
      check("b2b_spacing", pos_q[pos_q.size()-1] - pos_q[pos_q.size()-2], 1024);
    end else begin
      check("b2b_strobe_log", cnt_q.size(), 2);
    end

    // Reset after a partial window discards it.
    for (int i = 0; i < 500; i++) send(1'b1, 1'b0, 1'b1);
    base = cnt_q.size();
    do_reset();
    send(1'b0, 1'b0, 1'b0);
    #1;
    check("partial_no_strobe", cnt_q.size(), base);
    run_window(100, 1'b0, 1'b1);
    check_window("post_rst_win", 100, 1'b0, 1'b1, 1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
